sweep_sched: RTL and testbench
==============================

# sweep_sched

Frequency-sweep scheduler for the multi-channel NCO of the AWG. Holds per-channel start and step tuning words plus a shared point count and dwell time, programmed through a valid/ready config port. On `start` it steps every channel's tuning word in lockstep, holding each point for exactly the dwell time, and flags each change so the NCO retimes its phase accumulators. It sits between the control/register interface and the NCO, in the DAC sample-clock domain.

## Interface
- NCH, 4, number of NCO channels
- FTW_W, 32, tuning-word width
- CNT_W, 16, point-count width
- DWELL_W, 24, dwell-counter width
- clk  in  1  sample clock (MMCM output driving the NCO and DAC latches)
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid; equals !busy
- cfg_ch  in  $clog2(NCH)  target channel (ignored for shared registers)
- cfg_addr  in  2  0=start FTW[ch], 1=step FTW[ch], 2=points N (shared), 3=dwell D (shared)
- cfg_data  in  32  write data, truncated to the register width
- start  in  1  one-cycle sweep start request
- abort  in  1  one-cycle sweep abort request
- loop  in  1  continuous mode, sampled at end of each pass
- ftw  out  NCH*FTW_W  current tuning words, channel k at bits [k*FTW_W +: FTW_W]
- ftw_upd  out  1  one-cycle pulse, high in the first cycle a new ftw value is valid
- pt_idx  out  CNT_W  index of the current point, 0..N-1
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, DWELL, DONE.
- Reset (async, rst_n low): state IDLE; all config registers, ftw, pt_idx and dwell counter cleared to 0; busy=0, done=0, ftw_upd=0; cfg_ready=1.
- Config: cfg_valid && cfg_ready writes the register at the next edge. Only possible in IDLE. cfg_ch >= NCH with addr 0/1 is accepted and discarded. Writes while busy are stalled (cfg_ready=0), never dropped.
- D=0 is treated as D=1.
- IDLE + start, N>0: next cycle ftw[k]=start[k] for all k, pt_idx=0, ftw_upd=1, busy=1, state DWELL.
- IDLE + start, N=0: no ftw change; done=1 for one cycle next cycle; busy stays 0.
- DWELL: each point is held exactly D cycles. On the last cycle of a point:
  - pt_idx < N-1: ftw[k] += step[k] mod 2^FTW_W, wrapping silently; pt_idx++; ftw_upd=1.
  - pt_idx = N-1 and loop=1: ftw[k]=start[k], pt_idx=0, ftw_upd=1; remain busy.
  - pt_idx = N-1 and loop=0: go to DONE.
- DONE: lasts one cycle. done=1, busy=0, then IDLE. ftw and pt_idx hold the last point.
- abort, any state: next cycle IDLE, busy=0, done=0, ftw_upd=0. ftw and pt_idx hold current values.
- Simultaneous events:
  - abort beats start.
  - start while busy is ignored.
  - A config write and start in the same IDLE cycle: the sweep uses the pre-write values, and the write lands for the next sweep.
- Step values are two's-complement, so a down-sweep uses a negative step.

## Timing
- start sampled at edge T: first point visible at T+1 with ftw_upd.
- Point p becomes visible at T+1+p·D.
- Non-loop pass: done at T+1+N·D. busy high from T+1 through T+N·D inclusive.
- ftw_upd is never high on two consecutive cycles when D>1. When D=1 it is high every cycle of the sweep.
- All outputs are registered; no combinational path from inputs to ftw, ftw_upd, done or busy. cfg_ready is the registered busy, inverted.

## Test plan
- Reset mid-sweep: start (N=8, D=4), drop rst_n asynchronously at point 3 -> all outputs 0 immediately; cfg_ready=1; no done.
- Basic sweep: ch0 start=0x1000_0000, step=0x0100_0000, N=4, D=3, start at T -> ftw0 = 0x1000_0000, 0x1100_0000, 0x1200_0000, 0x1300_0000 at T+1/T+4/T+7/T+10; ftw_upd on those cycles; done at T+13.
- Wrap and negative step: ch1 start=0xFFFF_FFF0, step=0x20, N=2 -> second point 0x0000_0010. Ch2 step=0xFFFF_FFFF (−1) from 5, N=3 -> 5, 4, 3.
- Loop and abort: N=3, D=2, loop=1 -> ftw returns to start at T+7 with pt_idx=0. Assert abort at T+8 -> busy=0 at T+9, no done, ftw holds.
- Edge cases: D=0 behaves as D=1. N=0 start -> done one cycle later, no ftw_upd. cfg write during busy -> cfg_ready=0 and the write completes the cycle after done. start and abort together in IDLE -> nothing happens.
- Same-cycle write and start: write start[0]=0xA while issuing start -> sweep begins at the old start value; the next sweep begins at 0xA.

Source files
------------

// File: rtl/sweep_sched.sv
// Lockstep frequency-sweep scheduler for the multi-channel NCO: per-channel start/step
// tuning words, shared point count and dwell, registered outputs in the sample-clock domain.
module sweep_sched #(
  parameter int NCH     = 4,
  parameter int FTW_W   = 32,
  parameter int CNT_W   = 16,
  parameter int DWELL_W = 24,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Config handshake: a write happens on a rising edge where cfg_valid && cfg_ready.
  // The master holds cfg_ch/cfg_addr/cfg_data stable while cfg_valid is high and unaccepted.
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 loop,
  output logic [NCH*FTW_W-1:0] ftw,
  output logic                 ftw_upd,
  output logic [CNT_W-1:0]     pt_idx,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [FTW_W-1:0]   r_start [NCH];
  logic [FTW_W-1:0]   r_step  [NCH];
  logic [FTW_W-1:0]   r_ftw   [NCH];
  logic [CNT_W-1:0]   r_n;
  logic [DWELL_W-1:0] r_d;
  logic [CNT_W-1:0]   r_pt_idx;
  logic [DWELL_W-1:0] r_dcnt;
  logic               r_busy;
  logic               r_done;
  logic               r_upd;

  logic               w_cfg_fire;
  logic [DWELL_W-1:0] w_dwell_last;
  logic               w_last_cyc;
  logic               w_last_pt;
  logic               w_launch;
  logic               w_advance;
  logic               w_reload;

  assign w_cfg_fire   = cfg_valid && !r_busy;
  // A programmed dwell of 0 behaves exactly like a dwell of 1.
  assign w_dwell_last = (r_d == '0) ? '0 : (r_d - DWELL_W'(1));
  assign w_last_cyc   = (r_dcnt == w_dwell_last);
  assign w_last_pt    = (r_pt_idx == (r_n - CNT_W'(1)));

  assign w_launch  = (r_state == S_IDLE) && start && !abort && (r_n != '0);
  assign w_advance = (r_state == S_DWELL) && !abort && w_last_cyc && !w_last_pt;
  assign w_reload  = (r_state == S_DWELL) && !abort && w_last_cyc && w_last_pt && loop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!abort && start) begin
          w_next = (r_n == '0) ? S_DONE : S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_last_cyc && w_last_pt && !loop) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_upd    <= 1'b0;
      r_pt_idx <= '0;
      r_dcnt   <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_ftw[k] <= '0;
      end
    end else begin
      r_busy <= (w_next == S_DWELL);
      r_done <= (w_next == S_DONE);
      r_upd  <= w_launch || w_advance || w_reload;
      if (w_launch || w_advance || w_reload) begin
        r_dcnt <= '0;
      end else if (r_state == S_DWELL) begin
        r_dcnt <= r_dcnt + DWELL_W'(1);
      end
      if (w_launch || w_reload) begin
        r_pt_idx <= '0;
      end else if (w_advance) begin
        r_pt_idx <= r_pt_idx + CNT_W'(1);
      end
      for (int k = 0; k < NCH; k++) begin
        if (w_launch || w_reload) begin
          r_ftw[k] <= r_start[k];
        end else if (w_advance) begin
          r_ftw[k] <= r_ftw[k] + r_step[k];
        end
      end
    end
  end

  // A sweep launched in the same cycle as a write reads the pre-write values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= '0;
      r_d <= '0;
      for (int k = 0; k < NCH; k++) begin
        r_start[k] <= '0;
        r_step[k]  <= '0;
      end
    end else if (w_cfg_fire) begin
      case (cfg_addr)
        2'd0: if (int'(cfg_ch) < NCH) r_start[cfg_ch] <= cfg_data[FTW_W-1:0];
        2'd1: if (int'(cfg_ch) < NCH) r_step[cfg_ch]  <= cfg_data[FTW_W-1:0];
        2'd2: r_n <= cfg_data[CNT_W-1:0];
        default: r_d <= cfg_data[DWELL_W-1:0];
      endcase
    end
  end

  always_comb begin
    ftw = '0;
    for (int k = 0; k < NCH; k++) begin
      ftw[k*FTW_W +: FTW_W] = r_ftw[k];
    end
  end

  assign cfg_ready   = !r_busy;
  assign ftw_upd     = r_upd;
  assign pt_idx      = r_pt_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sweep_sched.sv
// Directed bench for sweep_sched: a per-cycle vector table for the basic sweep, hand-written
// sequences for reset, loop/abort, dwell 0, N=0 and config-stall corners, plus an ftw scoreboard.
module tb_sweep_sched;
  localparam int NCH = 4, FTW_W = 32, CNT_W = 16, DWELL_W = 24;
  localparam int W = NCH * FTW_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [1:0]       cfg_addr = '0;
  logic [31:0]      cfg_data = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             loop = 1'b0;
  logic [W-1:0]     ftw;
  logic             ftw_upd;
  logic [CNT_W-1:0] pt_idx;
  logic             busy;
  logic             done;
  logic [1:0]       o_dbg_state;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_start [NCH];
  logic [31:0]  m_step  [NCH];

  sweep_sched #(.NCH(NCH), .FTW_W(FTW_W), .CNT_W(CNT_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .loop(loop),
    .ftw(ftw), .ftw_upd(ftw_upd), .pt_idx(pt_idx),
    .busy(busy), .done(done), .o_dbg_state(o_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ftw_ch(input int k);
    return ftw[k*FTW_W +: FTW_W];
  endfunction

  function automatic logic [W-1:0] pack_pt(input int p);
    logic [W-1:0] v;
    logic [31:0] t;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      t = m_start[k] + (32'(p) * m_step[k]);
      v[k*FTW_W +: FTW_W] = t;
    end
    return v;
  endfunction

  task automatic push_sweep(input int n);
    for (int p = 0; p < n; p++) exp_q.push_back(pack_pt(p));
  endtask

  // Scoreboard: every ftw_upd must present the next expected tuning-word vector.
  always @(negedge clk) begin
    if (rst_n && ftw_upd) begin
      if (exp_q.size() == 0) check("upd_unexpected", W'(ftw_upd), W'(0));
      else check("upd_ftw", ftw, exp_q.pop_front());
    end
  end

  // Driver tasks: called right after a falling edge.
  task automatic cfg_write(input int ch, input int addr, input logic [31:0] data);
    logic acc;
    acc = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_addr = 2'(addr);
    cfg_data = data;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = cfg_ready;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    check("cfg_accept", W'(acc), W'(1));
    if (addr == 0) m_start[ch] = data;
    if (addr == 1) m_step[ch] = data;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] ftw0;
    logic        upd;
    logic [15:0] pt;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int seen;
    logic [W-1:0] hold;

    tbl[0]  = '{32'h1000_0000, 1'b1, 16'd0, 1'b1, 1'b0};
    tbl[1]  = '{32'h1000_0000, 1'b0, 16'd0, 1'b1, 1'b0};
    tbl[2]  = '{32'h1000_0000, 1'b0, 16'd0, 1'b1, 1'b0};
    tbl[3]  = '{32'h1100_0000, 1'b1, 16'd1, 1'b1, 1'b0};
    tbl[4]  = '{32'h1100_0000, 1'b0, 16'd1, 1'b1, 1'b0};
    tbl[5]  = '{32'h1100_0000, 1'b0, 16'd1, 1'b1, 1'b0};
    tbl[6]  = '{32'h1200_0000, 1'b1, 16'd2, 1'b1, 1'b0};
    tbl[7]  = '{32'h1200_0000, 1'b0, 16'd2, 1'b1, 1'b0};
    tbl[8]  = '{32'h1200_0000, 1'b0, 16'd2, 1'b1, 1'b0};
    tbl[9]  = '{32'h1300_0000, 1'b1, 16'd3, 1'b1, 1'b0};
    tbl[10] = '{32'h1300_0000, 1'b0, 16'd3, 1'b1, 1'b0};
    tbl[11] = '{32'h1300_0000, 1'b0, 16'd3, 1'b1, 1'b0};
    tbl[12] = '{32'h1300_0000, 1'b0, 16'd3, 1'b0, 1'b1};
    tbl[13] = '{32'h1300_0000, 1'b0, 16'd3, 1'b0, 1'b0};
    for (int k = 0; k < NCH; k++) begin
      m_start[k] = '0;
      m_step[k] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ftw", ftw, '0);
    check("reset_flags", W'({ftw_upd, pt_idx, busy, done, cfg_ready}), W'({1'b0, 16'd0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-sweep at point 3
    cfg_write(0, 0, 32'h0000_0100);
    cfg_write(0, 1, 32'h0000_0010);
    cfg_write(0, 2, 32'd8);
    cfg_write(0, 3, 32'd4);
    push_sweep(4);
    pulse_start();
    repeat (12) @(negedge clk);
    check("mid_pt3", W'(pt_idx), W'(3));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ftw", ftw, '0);
    check("async_rst_flags", W'({ftw_upd, pt_idx, busy, done, cfg_ready}), W'({1'b0, 16'd0, 1'b0, 1'b0, 1'b1}));
    for (int k = 0; k < NCH; k++) begin
      m_start[k] = '0;
      m_step[k] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", W'(seen), W'(0));
    check("rst_q_drained", W'(exp_q.size()), W'(0));

    // Basic sweep, table driven; other channels cover wrap, negative and large steps
    cfg_write(0, 0, 32'h1000_0000);
    cfg_write(0, 1, 32'h0100_0000);
    cfg_write(1, 0, 32'hFFFF_FFF0);
    cfg_write(1, 1, 32'h0000_0020);
    cfg_write(2, 0, 32'd5);
    cfg_write(2, 1, 32'hFFFF_FFFF);
    cfg_write(3, 0, 32'h8000_0000);
    cfg_write(3, 1, 32'h1234_5678);
    cfg_write(0, 2, 32'd4);
    cfg_write(0, 3, 32'd3);
    push_sweep(4);
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      check($sformatf("basic_k%0d", i + 1),
            W'({ftw_ch(0), ftw_upd, pt_idx, busy, done, cfg_ready}),
            W'({tbl[i], ~tbl[i].busy}));
      @(negedge clk);
    end

    // Dwell 0 acts as dwell 1: upd every cycle; ch1 wraps, ch2 counts down
    cfg_write(0, 2, 32'd3);
    cfg_write(0, 3, 32'd0);
    push_sweep(3);
    pulse_start();
    check("d0_p0", W'({ftw_ch(1), ftw_ch(2), ftw_upd, busy}), W'({32'hFFFF_FFF0, 32'd5, 1'b1, 1'b1}));
    @(negedge clk);
    check("d0_p1", W'({ftw_ch(1), ftw_ch(2), ftw_upd, busy}), W'({32'h0000_0010, 32'd4, 1'b1, 1'b1}));
    @(negedge clk);
    check("d0_p2", W'({ftw_ch(1), ftw_ch(2), ftw_upd, busy}), W'({32'h0000_0030, 32'd3, 1'b1, 1'b1}));
    @(negedge clk);
    check("d0_done", W'({done, busy, ftw_upd}), W'(3'b100));
    @(negedge clk);
    check("d0_after", W'({done, busy}), W'(2'b00));

    // Loop then abort
    cfg_write(0, 2, 32'd3);
    cfg_write(0, 3, 32'd2);
    loop = 1'b1;
    push_sweep(3);
    exp_q.push_back(pack_pt(0));
    pulse_start();
    repeat (6) @(negedge clk);
    check("loop_reload", W'({pt_idx, ftw_upd, busy, ftw_ch(0)}), W'({16'd0, 1'b1, 1'b1, 32'h1000_0000}));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    loop = 1'b0;
    check("abort_flags", W'({busy, done, ftw_upd, pt_idx}), W'({1'b0, 1'b0, 1'b0, 16'd0}));
    check("abort_ftw_hold", ftw, pack_pt(0));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy || ftw !== pack_pt(0)) seen++;
    end
    check("abort_quiet", W'(seen), W'(0));

    // N=0: done next cycle, no ftw change
    cfg_write(0, 2, 32'd0);
    hold = pack_pt(0);
    pulse_start();
    check("n0_done", W'({done, busy, ftw_upd}), W'(3'b100));
    check("n0_ftw_hold", ftw, hold);
    @(negedge clk);
    check("n0_after", W'(done), W'(0));

    // start with abort in IDLE: nothing happens
    cfg_write(0, 2, 32'd2);
    cfg_write(0, 3, 32'd2);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    seen = 0;
    repeat (4) begin
      if (busy || done || ftw_upd) seen++;
      @(negedge clk);
    end
    check("start_abort_idle", W'(seen), W'(0));

    // Config write during busy stalls, then lands after done
    push_sweep(2);
    pulse_start();
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_addr = 2'd0;
    cfg_data = 32'h0000_0055;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_k%0d", i + 1), W'({cfg_ready, busy}), W'(2'b01));
      @(negedge clk);
    end
    check("stall_done", W'({cfg_ready, done, busy}), W'(3'b110));
    @(negedge clk);
    cfg_valid = 1'b0;
    m_start[0] = 32'h0000_0055;
    push_sweep(2);
    pulse_start();
    check("stall_landed", W'(ftw_ch(0)), W'(32'h0000_0055));
    repeat (4) @(negedge clk);
    check("stall_sweep_done", W'(done), W'(1));
    @(negedge clk);

    // Same-cycle write and start: sweep uses the old start word
    push_sweep(2);
    cfg_valid = 1'b1;
    cfg_ch = 2'd0;
    cfg_addr = 2'd0;
    cfg_data = 32'h0000_000A;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    m_start[0] = 32'h0000_000A;
    check("same_cycle_old", W'(ftw_ch(0)), W'(32'h0000_0055));
    repeat (4) @(negedge clk);
    check("same_cycle_done", W'(done), W'(1));
    @(negedge clk);
    push_sweep(2);
    pulse_start();
    check("same_cycle_new", W'(ftw_ch(0)), W'(32'h0000_000A));
    repeat (4) @(negedge clk);
    check("same_cycle_done2", W'(done), W'(1));
    @(negedge clk);

    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
